dma_req_arbiter: RTL and testbench
==================================

DMA_REQ_ARBITER -- requirements
Module: dma_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of layer controllers sharing one dma_engineer.
REQ-002 Parameter AW, default 27: address and length width.
REQ-003 Parameter DW, default 512: DMA data width.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_vec  in  N_REQ  per-requester dma_engineer_req; held high until acked.
REQ-007 req_start_addr  in  N_REQ*AW  packed start addresses; requester i uses slice [i*AW +: AW].
REQ-008 req_length  in  N_REQ*AW  packed lengths; same slicing as REQ-007.
REQ-009 ack_vec  out  N_REQ  one-cycle ack pulse to the granted requester.
REQ-010 dout_en_vec  out  N_REQ  dma_dout_en routed to the granted requester only.
REQ-011 dout_eop_vec  out  N_REQ  dma_dout_eop routed to the granted requester only.
REQ-012 dout  out  DW  dma_dout broadcast to all requesters.
REQ-013 dma_req  out  1; dma_ack  in  1  request/ack pair towards the engineer.
REQ-014 dma_start_addr, dma_length  out  AW each  latched parameters of the granted request.
REQ-015 dma_dout_en, dma_dout_eop  in  1 each; dma_dout  in  DW  engineer data stream.
REQ-016 grant_id  out  clog2(N_REQ)  current owner; busy  out  1  high outside IDLE; err_stray  out  1  one-cycle pulse.

Function
REQ-017 FSM states: IDLE, ISSUE, XFER.
REQ-018 IDLE: when any req_vec bit is high, the block selects the winner round-robin starting at pointer rr_ptr, registers grant_id, dma_start_addr and dma_length, and enters ISSUE on the next cycle.
REQ-019 ISSUE: dma_req is high (registered) and the latched address and length are held stable until dma_ack.
REQ-020 ISSUE with dma_ack=1: dma_req drops next cycle, ack_vec[grant_id] pulses in the same cycle (combinational), and the FSM enters XFER.
REQ-021 XFER: dout_en_vec[grant_id] = dma_dout_en and dout_eop_vec[grant_id] = dma_dout_eop, combinationally; all other bits are 0.
REQ-022 XFER with dma_dout_en & dma_dout_eop: the FSM enters IDLE and rr_ptr = grant_id+1, wrapping at N_REQ.
REQ-023 Length 0 winner: no ISSUE state is entered; ack_vec[winner] pulses in the IDLE cycle after selection, rr_ptr advances, and the FSM stays in IDLE.
REQ-024 dma_dout_en outside XFER: the data is dropped and err_stray pulses for one cycle.
REQ-025 A new request arriving in the same cycle as eop is not arbitrated that cycle; arbitration occurs in the following IDLE cycle, with minimum 1 IDLE cycle between grants.
REQ-026 req_vec changes during ISSUE/XFER do not affect the latched grant.
REQ-027 Latency: req high to dma_req high is exactly 2 cycles (IDLE select, ISSUE).
REQ-028 dma_ack outside ISSUE: it is ignored, and no ack_vec pulse occurs.

Reset
REQ-029 rst=1 forces IDLE, rr_ptr=0, grant_id=0, dma_req=0, dma_start_addr=0, dma_length=0, err_stray=0 and busy=0; ack_vec, dout_en_vec and dout_eop_vec are 0.
REQ-030 Reset mid-ISSUE or mid-XFER abandons the transfer, with no ack or eop issued; residual engineer beats after reset flag err_stray.

Structure
REQ-031 The shared package/header holds the FSM state encoding (IDLE=0, ISSUE=1, XFER=2), a clog2 function and default AW/DW constants.
REQ-032 Sub-module rr_arbiter is combinational: req_vec and rr_ptr in, one-hot winner and index out; it is instantiated once.

Verification
REQ-033 Single request: req_vec=0001, addr=0x100, len=128; ack after 3 cycles and 128 beats with eop on beat 128 -> dma_start_addr=0x100, dma_length=128, ack_vec=0001 pulse once, dout_en_vec[0] high for 128 beats, others 0.
REQ-034 Fairness: req_vec=1111 held continuously -> grants in order 0,1,2,3,0, with each dma_req 2 cycles after the previous eop.
REQ-035 Zero length: req 2 with len=0 plus req 3 with len=64 -> ack_vec[2] without dma_req, then requester 3 is served normally.
REQ-036 Stray data: dma_dout_en pulsed while in IDLE -> err_stray=1 for one cycle, and all dout_en_vec bits stay 0.
REQ-037 Reset mid-XFER at beat 10 of 128 -> next cycle busy=0 and dma_req=0, rr_ptr=0, with no eop routed.

Source files
------------

// File: rtl/dma_req_arbiter_pkg.sv
// Shared types and constants for the DMA request arbiter: FSM encoding,
// default bus widths and a constant-foldable clog2 helper.
package dma_req_arbiter_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_AW    = 27;
    localparam int unsigned DEF_DW    = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } state_t;

    // Never returns 0 so that index fields stay at least one bit wide.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/dma_req_arbiter_if.sv
// Bundle of requester-side and engineer-side signals around the arbiter.
// master is the arbiter's view; slave is the view of the surrounding logic.
interface dma_req_arbiter_if
    import dma_req_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) ();
    localparam int unsigned IW = clog2(N_REQ);

    logic [N_REQ-1:0]    req_vec;
    logic [N_REQ*AW-1:0] req_start_addr;
    logic [N_REQ*AW-1:0] req_length;
    logic [N_REQ-1:0]    ack_vec;
    logic [N_REQ-1:0]    dout_en_vec;
    logic [N_REQ-1:0]    dout_eop_vec;
    logic [DW-1:0]       dout;

    logic                dma_req;
    logic                dma_ack;
    logic [AW-1:0]       dma_start_addr;
    logic [AW-1:0]       dma_length;
    logic                dma_dout_en;
    logic                dma_dout_eop;
    logic [DW-1:0]       dma_dout;

    logic [IW-1:0]       grant_id;
    logic                busy;
    logic                err_stray;

    modport master (
        input  req_vec, req_start_addr, req_length,
        output ack_vec, dout_en_vec, dout_eop_vec, dout,
        output dma_req, dma_start_addr, dma_length,
        input  dma_ack, dma_dout_en, dma_dout_eop, dma_dout,
        output grant_id, busy, err_stray
    );

    modport slave (
        output req_vec, req_start_addr, req_length,
        input  ack_vec, dout_en_vec, dout_eop_vec, dout,
        input  dma_req, dma_start_addr, dma_length,
        output dma_ack, dma_dout_en, dma_dout_eop, dma_dout,
        input  grant_id, busy, err_stray
    );

endinterface

// File: rtl/dma_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins,
// returned both as a one-hot vector and as an index.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx,
    output logic             valid
);

    logic [IW-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = IW'((32'(rr_ptr) + off) % N_REQ);
            if (!valid && req_vec[cand]) begin
                valid        = 1'b1;
                winner_idx   = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_req_arbiter.sv
// Shares one DMA engineer between N_REQ layer controllers: round-robin grant,
// latched request parameters, and routing of the engineer's data strobes.
module dma_req_arbiter
    import dma_req_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic              clk,
    input  logic              rst,
    dma_req_arbiter_if.master bus
);

    localparam int unsigned IW = clog2(N_REQ);

    state_t           state;
    logic [IW-1:0]    grant_id;
    logic [IW-1:0]    rr_ptr;
    logic [AW-1:0]    start_addr;
    logic [AW-1:0]    length;
    logic             dma_req;
    logic             busy;
    logic             err_stray;
    logic [N_REQ-1:0] zl_ack;

    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]    win_idx;
    logic             win_valid;
    logic [AW-1:0]    win_addr;
    logic [AW-1:0]    win_len;
    logic             arb_en;

    logic [N_REQ-1:0] grant_oh;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] en_vec;
    logic [N_REQ-1:0] eop_vec;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
        return (32'(id) == N_REQ - 1) ? '0 : id + IW'(1);
    endfunction

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .req_vec    (bus.req_vec),
        .rr_ptr     (rr_ptr),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .valid      (win_valid)
    );

    // The cycle carrying a zero-length ack is not arbitrated: the acked
    // requester still has its request raised during it.
    assign arb_en   = (state == IDLE) && (zl_ack == '0);
    assign win_addr = bus.req_start_addr[32'(win_idx) * AW +: AW];
    assign win_len  = bus.req_length[32'(win_idx) * AW +: AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            start_addr <= '0;
            length     <= '0;
            dma_req    <= 1'b0;
            busy       <= 1'b0;
            err_stray  <= 1'b0;
            zl_ack     <= '0;
        end else begin
            err_stray <= bus.dma_dout_en && (state != XFER);
            zl_ack    <= '0;
            case (state)
                IDLE: begin
                    if (arb_en && win_valid) begin
                        grant_id   <= win_idx;
                        start_addr <= win_addr;
                        length     <= win_len;
                        if (win_len == '0) begin
                            zl_ack <= win_onehot;
                            rr_ptr <= next_ptr(win_idx);
                        end else begin
                            state   <= ISSUE;
                            dma_req <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.dma_ack) begin
                        state   <= XFER;
                        dma_req <= 1'b0;
                    end
                end
                XFER: begin
                    if (bus.dma_dout_en && bus.dma_dout_eop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr(grant_id);
                    end
                end
                default: begin
                    state   <= IDLE;
                    dma_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Requester-facing strobes follow the engineer in the same cycle.
    always_comb begin
        grant_oh           = '0;
        grant_oh[grant_id] = 1'b1;
        ack                = '0;
        en_vec             = '0;
        eop_vec            = '0;
        if (!rst) begin
            ack = zl_ack;
            if ((state == ISSUE) && bus.dma_ack) begin
                ack = grant_oh;
            end
            if (state == XFER) begin
                if (bus.dma_dout_en) begin
                    en_vec = grant_oh;
                end
                if (bus.dma_dout_eop) begin
                    eop_vec = grant_oh;
                end
            end
        end
    end

    assign bus.ack_vec        = ack;
    assign bus.dout_en_vec    = en_vec;
    assign bus.dout_eop_vec   = eop_vec;
    assign bus.dout           = bus.dma_dout;
    assign bus.dma_req        = dma_req;
    assign bus.dma_start_addr = start_addr;
    assign bus.dma_length     = length;
    assign bus.grant_id       = grant_id;
    assign bus.busy           = busy;
    assign bus.err_stray      = err_stray;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: a small engineer model serves grants
// popped from an expected-grant queue filled as requests are raised.
module tb_dma_req_arbiter;
    import dma_req_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = DEF_AW;
    localparam int unsigned DW = DEF_DW;
    localparam int unsigned IW = clog2(N);

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_req_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    dma_req_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] r;
        for (int k = 0; k < int'(DW / 32); k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        bus.req_start_addr[i*AW +: AW] = addr;
        bus.req_length[i*AW +: AW]     = len;
    endtask

    task automatic push(input int i, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        exp_t e;
        e.id   = IW'(i);
        e.addr = addr;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // Wait for dma_req, compare against the next expected grant, ack after
    // ack_wait ISSUE cycles, then stream len beats (or reset at abort_beat).
    task automatic serve(input int unsigned exp_lat, input int unsigned ack_wait,
                         input bit drop_req, input int unsigned abort_beat);
        exp_t          e;
        int unsigned   lat    = 0;
        int unsigned   routed = 0;
        logic [N-1:0]  g;
        logic [N*AW-1:0] saved;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            if (bus.dma_req === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("dma_req_latency", 64'(lat), 64'(exp_lat));
        if (lat == 0) return;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        g = N'(1) << e.id;
        check("grant_id", 64'(bus.grant_id), 64'(e.id));
        check("dma_start_addr", 64'(bus.dma_start_addr), 64'(e.addr));
        check("dma_length", 64'(bus.dma_length), 64'(e.len));
        check("busy_issue", 64'(bus.busy), 64'(1));
        saved = bus.req_start_addr;
        repeat (ack_wait) begin
            bus.req_start_addr = (N*AW)'({$urandom, $urandom, $urandom, $urandom});
            tick();
            #1;
            check("addr_hold", 64'(bus.dma_start_addr), 64'(e.addr));
            check("dma_req_hold", 64'(bus.dma_req), 64'(1));
        end
        bus.req_start_addr = saved;
        bus.dma_ack = 1'b1;
        #1;
        check("ack_vec_pulse", 64'(bus.ack_vec), 64'(g));
        tick();
        bus.dma_ack = 1'b0;
        if (drop_req) bus.req_vec[e.id] = 1'b0;
        #1;
        check("ack_vec_after", 64'(bus.ack_vec), 64'(0));
        check("dma_req_drop", 64'(bus.dma_req), 64'(0));
        for (int unsigned b = 1; b <= 32'(e.len); b++) begin
            if (b == abort_beat) begin
                check("beats_before_reset", 64'(routed), 64'(abort_beat - 1));
                rst = 1'b1;
                bus.dma_dout_en = 1'b1;
                bus.dma_dout_eop = 1'b0;
                tick();
                return;
            end
            bus.dma_dout     = rand_dw();
            bus.dma_dout_en  = 1'b1;
            bus.dma_dout_eop = (b == 32'(e.len));
            #1;
            if (bus.dout_en_vec === g &&
                bus.dout_eop_vec === (bus.dma_dout_eop ? g : N'(0)) &&
                bus.dout === bus.dma_dout)
                routed++;
            tick();
        end
        bus.dma_dout_en  = 1'b0;
        bus.dma_dout_eop = 1'b0;
        check("beats_routed", 64'(routed), 64'(e.len));
    endtask

    initial begin
        rst                = 1'b1;
        bus.req_vec        = '0;
        bus.req_start_addr = '0;
        bus.req_length     = '0;
        bus.dma_ack        = 1'b0;
        bus.dma_dout_en    = 1'b0;
        bus.dma_dout_eop   = 1'b0;
        bus.dma_dout       = '0;
        tick();
        tick();
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_dma_req", 64'(bus.dma_req), 64'(0));
        check("rst_grant_id", 64'(bus.grant_id), 64'(0));
        check("rst_addr", 64'(bus.dma_start_addr), 64'(0));
        check("rst_len", 64'(bus.dma_length), 64'(0));
        check("rst_err_stray", 64'(bus.err_stray), 64'(0));
        check("rst_ack_vec", 64'(bus.ack_vec), 64'(0));
        check("rst_en_vec", 64'(bus.dout_en_vec), 64'(0));
        check("rst_eop_vec", 64'(bus.dout_eop_vec), 64'(0));
        rst = 1'b0;
        tick();

        // Stray beat and stray ack while idle.
        bus.dma_dout_en = 1'b1;
        bus.dma_ack     = 1'b1;
        #1;
        check("stray_en_vec", 64'(bus.dout_en_vec), 64'(0));
        check("stray_ack_vec", 64'(bus.ack_vec), 64'(0));
        tick();
        bus.dma_dout_en = 1'b0;
        bus.dma_ack     = 1'b0;
        #1;
        check("err_stray_pulse", 64'(bus.err_stray), 64'(1));
        check("stray_busy", 64'(bus.busy), 64'(0));
        tick();
        #1;
        check("err_stray_clear", 64'(bus.err_stray), 64'(0));

        // Fairness with all requests held.
        for (int i = 0; i < int'(N); i++) set_req(i, AW'(32'h1000 * (i + 1)), AW'(4 + i));
        bus.req_vec = '1;
        push(0, AW'(32'h1000), AW'(4));
        push(1, AW'(32'h2000), AW'(5));
        push(2, AW'(32'h3000), AW'(6));
        push(3, AW'(32'h4000), AW'(7));
        push(0, AW'(32'h1000), AW'(4));
        serve(1, 0, 1'b0, 0);
        serve(1, 1, 1'b0, 0);
        serve(1, 0, 1'b0, 0);
        serve(1, 2, 1'b0, 0);
        serve(1, 0, 1'b0, 0);
        bus.req_vec = '0;

        // Single 128-beat request.
        set_req(0, AW'(32'h100), AW'(128));
        bus.req_vec = 4'b0001;
        push(0, AW'(32'h100), AW'(128));
        serve(1, 3, 1'b1, 0);

        // Zero-length request beside a normal one.
        set_req(2, AW'(32'h300), AW'(0));
        set_req(3, AW'(32'h400), AW'(64));
        bus.req_vec = 4'b1100;
        push(3, AW'(32'h400), AW'(64));
        tick();
        #1;
        check("zl_ack_vec", 64'(bus.ack_vec), 64'(4'b0100));
        check("zl_no_dma_req", 64'(bus.dma_req), 64'(0));
        check("zl_busy", 64'(bus.busy), 64'(0));
        bus.req_vec[2] = 1'b0;
        tick();
        #1;
        check("zl_ack_once", 64'(bus.ack_vec), 64'(0));
        check("zl_still_no_req", 64'(bus.dma_req), 64'(0));
        serve(1, 0, 1'b1, 0);

        // Move rr_ptr off zero, then reset in the middle of a transfer.
        set_req(1, AW'(32'h500), AW'(2));
        bus.req_vec = 4'b0010;
        push(1, AW'(32'h500), AW'(2));
        serve(1, 0, 1'b1, 0);
        set_req(2, AW'(32'h600), AW'(128));
        bus.req_vec = 4'b0100;
        push(2, AW'(32'h600), AW'(128));
        serve(1, 1, 1'b1, 10);
        rst = 1'b0;
        bus.dma_dout_en = 1'b1;
        #1;
        check("post_rst_busy", 64'(bus.busy), 64'(0));
        check("post_rst_dma_req", 64'(bus.dma_req), 64'(0));
        check("post_rst_en_vec", 64'(bus.dout_en_vec), 64'(0));
        check("post_rst_grant_id", 64'(bus.grant_id), 64'(0));
        check("post_rst_len", 64'(bus.dma_length), 64'(0));
        check("post_rst_err", 64'(bus.err_stray), 64'(0));
        tick();
        bus.dma_dout_eop = 1'b1;
        #1;
        check("residual_eop_vec", 64'(bus.dout_eop_vec), 64'(0));
        check("residual_en_vec", 64'(bus.dout_en_vec), 64'(0));
        check("residual_err_1", 64'(bus.err_stray), 64'(1));
        tick();
        bus.dma_dout_en  = 1'b0;
        bus.dma_dout_eop = 1'b0;
        #1;
        check("residual_err_2", 64'(bus.err_stray), 64'(1));
        tick();
        #1;
        check("residual_err_clear", 64'(bus.err_stray), 64'(0));
        check("residual_busy", 64'(bus.busy), 64'(0));

        // rr_ptr must be back at 0: requester 0 wins among all four.
        for (int i = 0; i < int'(N); i++) set_req(i, AW'(32'h1000 * (i + 1)), AW'(4 + i));
        bus.req_vec = '1;
        push(0, AW'(32'h1000), AW'(4));
        serve(1, 0, 1'b0, 0);
        bus.req_vec = '0;
        tick();
        tick();
        #1;
        check("final_busy", 64'(bus.busy), 64'(0));
        check("final_dma_req", 64'(bus.dma_req), 64'(0));
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
